fir_src: RTL and testbench
==========================

FIR_SRC -- requirements
Module: fir_src

Interface
REQ-001 Parameter bW, default 8: sample width.
REQ-002 Parameter hC, default 5: golden-model tap count.
REQ-003 Parameter hClog2, default 3: sum guard bits; 2**hClog2 >= hC is required.
REQ-004 Parameter SEED, default 16'hACE1: LFSR seed; must be nonzero.
REQ-005 clk  in  1  single clock; all logic on posedge.
REQ-006 rst  in  1  synchronous, active-high reset.
REQ-007 start  in  1  pulse that begins a burst.
REQ-008 burst_len  in  16  number of samples in the burst.
REQ-009 gap  in  4  idle cycles inserted between samples.
REQ-010 x  out  bW  sample data.
REQ-011 x_valid  out  1  sample offered.
REQ-012 x_ready  in  1  sink accepts the sample.
REQ-013 busy  out  1  burst in progress.
REQ-014 done  out  1  one-cycle pulse at burst end.
REQ-015 y_g  out  bW  golden moving-average output (FIR_SRC_GOLDEN_EN only).
REQ-016 y_g_valid  out  1  golden output strobe (FIR_SRC_GOLDEN_EN only).

Function
REQ-017 The FSM SHALL have states IDLE, RUN, GAP and DONE.
REQ-018 IDLE + start: latch burst_len and gap; go to RUN if burst_len != 0, else go to DONE.
REQ-019 RUN SHALL drive x_valid=1; an accept is a cycle with x_valid && x_ready.
REQ-020 While x_valid=1 && x_ready=0, x SHALL hold its value.
REQ-021 On an accept, decrement the remaining count; if it reaches 0, go to DONE; else if latched gap != 0, go to GAP; else stay in RUN with the next sample presented in the next cycle.
REQ-022 GAP SHALL hold x_valid=0 for exactly the latched gap cycles, then return to RUN.
REQ-023 DONE SHALL assert done for one cycle, then go to IDLE.
REQ-024 busy SHALL be 1 in RUN, GAP and DONE, and 0 in IDLE.
REQ-025 start SHALL be ignored unless the FSM is in IDLE, including in the DONE cycle.
REQ-026 x SHALL equal lfsr[bW-1:0], where lfsr is a 16-bit Galois right-shift LFSR with mask 16'hB400.
REQ-027 The LFSR SHALL advance only on an accept.
REQ-028 The LFSR SHALL NOT reset between bursts.
REQ-029 The golden model SHALL keep a shift register h[1..hC], cleared on rst and on an accepted start, that shifts in x on each accept.
REQ-030 y_g SHALL equal (sum of h[1..hC], computed at width bW+hClog2) >> 3, truncated to bW bits.
REQ-031 y_g_valid SHALL pulse in the cycle after each accept, with y_g already updated in that cycle.

Reset
REQ-032 rst SHALL force: FSM=IDLE; lfsr=SEED; x_valid=0; busy=0; done=0; x=SEED[bW-1:0].
REQ-033 rst SHALL also force h=0, y_g=0 and y_g_valid=0.
REQ-034 rst asserted mid-burst SHALL abort the burst with no done pulse.
REQ-035 An accept in the same cycle as rst SHALL be discarded.

Configuration
REQ-036 With FIR_SRC_GOLDEN_EN defined, the golden model, y_g and y_g_valid SHALL be present.
REQ-037 Without FIR_SRC_GOLDEN_EN, y_g and y_g_valid SHALL be absent and no golden logic SHALL be built.

Structure
REQ-038 Package fir_pkg SHALL hold: the state enum, the LFSR mask and the default seed constants, and the shift amount 3.
REQ-039 The golden model SHALL be the sub-module fir_src_gold.

Verification
REQ-040 rst, then start with burst_len=3, gap=0, x_ready=1 -> x = 8'hE1, 8'h70, 8'h38 on consecutive cycles, then done pulses once.
REQ-041 Same stimulus with FIR_SRC_GOLDEN_EN defined -> y_g = 28, then 42, then 49.
REQ-042 burst_len=2, gap=3 -> x_valid high 1 cycle, low 3 cycles, high 1 cycle, then done.
REQ-043 x_ready low for 4 cycles while x_valid=1 -> x holds 8'hE1 and the LFSR does not advance.
REQ-044 burst_len=0 -> done pulses 1 cycle after start with no x_valid; a start during busy is ignored.
REQ-045 rst after the 2nd accept of a 5-sample burst -> IDLE, no done pulse, and the next burst begins at x=8'hE1.

Source files
------------

// File: rtl/fir_pkg.sv
// Shared constants for the fir_src burst stimulus generator: FSM state codes,
// LFSR polynomial/seed, golden-model averaging shift and the LFSR step function.
package fir_pkg;

    typedef logic [1:0] fir_state_t;

    localparam fir_state_t ST_IDLE = 2'd0;
    localparam fir_state_t ST_RUN  = 2'd1;
    localparam fir_state_t ST_GAP  = 2'd2;
    localparam fir_state_t ST_DONE = 2'd3;

    localparam logic [15:0] LFSR_MASK = 16'hB400;
    localparam logic [15:0] LFSR_SEED = 16'hACE1;
    localparam int          AVG_SHIFT = 3;

    // Galois right-shift step: feed the outgoing LSB back through the mask
    function automatic logic [15:0] lfsr_next(input logic [15:0] cur);
        return (cur >> 1) ^ (cur[0] ? LFSR_MASK : 16'h0000);
    endfunction

endpackage

// File: rtl/fir_src_gold.sv
// Golden moving-sum model: hC-deep shift register of accepted samples, output is
// the tap sum >> AVG_SHIFT. Only instantiated when FIR_SRC_GOLDEN_EN is defined.
module fir_src_gold
    import fir_pkg::*;
#(
    parameter int bW     = 8,
    parameter int hC     = 5,
    parameter int hClog2 = 3
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          clr,
    input  logic          acc,
    input  logic [bW-1:0] x_in,
    output logic [bW-1:0] y_g,
    output logic          y_g_valid
);

    localparam int SW = bW + hClog2;

    logic [hC:1][bW-1:0] h;
    logic [SW-1:0]       sum;
    logic [1:0]          vld_pipe;

    assign vld_pipe[0] = acc;

    always_ff @(posedge clk) begin
        if (rst || clr) begin
            h <= '0;
        end else if (acc) begin
            h[1] <= x_in;
            for (int i = 2; i <= hC; i++) h[i] <= h[i-1];
        end
    end

    always_ff @(posedge clk) begin
        if (rst) vld_pipe[1] <= 1'b0;
        else     vld_pipe[1] <= vld_pipe[0];
    end

    // Sum reads the registered taps, so it is already current in the strobe cycle
    always_comb begin
        sum = '0;
        for (int i = 1; i <= hC; i++) sum = sum + SW'(h[i]);
    end

    assign y_g       = bW'(sum >> AVG_SHIFT);
    assign y_g_valid = vld_pipe[1];

endmodule

// File: rtl/fir_src.sv
// Burst sample source: LFSR data on a valid/ready stream with optional inter-sample
// gaps. Golden averaging model and y_g/y_g_valid ports exist only with FIR_SRC_GOLDEN_EN.
module fir_src
    import fir_pkg::*;
#(
    parameter int          bW     = 8,
    parameter int          hC     = 5,
    parameter int          hClog2 = 3,
    parameter logic [15:0] SEED   = LFSR_SEED
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          start,
    input  logic [15:0]   burst_len,
    input  logic [3:0]    gap,
    output logic [bW-1:0] x,
    output logic          x_valid,
    input  logic          x_ready,
    output logic          busy,
`ifdef FIR_SRC_GOLDEN_EN
    output logic [bW-1:0] y_g,
    output logic          y_g_valid,
`endif
    output logic          done
);

    fir_state_t  state;
    logic [15:0] lfsr;
    logic [15:0] remain;
    logic [3:0]  gap_l;
    logic [3:0]  gcnt;
    logic        accept;
    logic        start_acc;

    assign accept    = (state == ST_RUN) && x_ready;
    assign start_acc = (state == ST_IDLE) && start;

    always_ff @(posedge clk) begin
        if (rst) begin
            state  <= ST_IDLE;
            lfsr   <= SEED;
            remain <= '0;
            gap_l  <= '0;
            gcnt   <= '0;
        end else begin
            case (state)
                ST_IDLE: if (start) begin
                    remain <= burst_len;
                    gap_l  <= gap;
                    state  <= (burst_len != 16'd0) ? ST_RUN : ST_DONE;
                end
                ST_RUN: if (x_ready) begin
                    lfsr   <= lfsr_next(lfsr);
                    remain <= remain - 16'd1;
                    if (remain == 16'd1) begin
                        state <= ST_DONE;
                    end else if (gap_l != 4'd0) begin
                        state <= ST_GAP;
                        gcnt  <= gap_l;
                    end
                end
                ST_GAP: begin
                    if (gcnt == 4'd1) state <= ST_RUN;
                    else              gcnt  <= gcnt - 4'd1;
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

    assign x       = lfsr[bW-1:0];
    assign x_valid = (state == ST_RUN);
    assign busy    = (state != ST_IDLE);
    assign done    = (state == ST_DONE);

`ifdef FIR_SRC_GOLDEN_EN
    fir_src_gold #(
        .bW     (bW),
        .hC     (hC),
        .hClog2 (hClog2)
    ) u_gold (
        .clk       (clk),
        .rst       (rst),
        .clr       (start_acc),
        .acc       (accept),
        .x_in      (x),
        .y_g       (y_g),
        .y_g_valid (y_g_valid)
    );
`else
    // Guard bits must cover the tap count even when the model is not built
    if ((2 ** hClog2) < hC) begin : g_cfg_bad
        $error("fir_src: 2**hClog2 must be >= hC");
    end
`endif

endmodule

// File: tb/tb_fir_src.sv
// Directed bench for fir_src; golden-output checks are compiled in with FIR_SRC_GOLDEN_EN.
module tb_fir_src;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic [15:0] burst_len;
    logic [3:0]  gap;
    logic [7:0]  x;
    logic        x_valid;
    logic        x_ready;
    logic        busy;
    logic        done;
`ifdef FIR_SRC_GOLDEN_EN
    logic [7:0]  y_g;
    logic        y_g_valid;
`endif

    int errors = 0;
    int checks = 0;

    fir_src dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .burst_len (burst_len),
        .gap       (gap),
        .x         (x),
        .x_valid   (x_valid),
        .x_ready   (x_ready),
        .busy      (busy),
`ifdef FIR_SRC_GOLDEN_EN
        .y_g       (y_g),
        .y_g_valid (y_g_valid),
`endif
        .done      (done)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(negedge clk);
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    initial begin
        rst = 1'b1; start = 1'b0; burst_len = '0; gap = '0; x_ready = 1'b1;
        tick(); tick();

        // reset state
        chk("rst_x_valid", 32'(x_valid), 0);
        chk("rst_busy",    32'(busy),    0);
        chk("rst_done",    32'(done),    0);
        chk("rst_x",       32'(x),       32'hE1);
`ifdef FIR_SRC_GOLDEN_EN
        chk("rst_y_g",     32'(y_g),       0);
        chk("rst_y_vld",   32'(y_g_valid), 0);
`endif
        rst = 1'b0;
        tick();

        // burst of 3, no gap, sink always ready
        start = 1'b1; burst_len = 16'd3; gap = 4'd0;
        tick(); start = 1'b0;
        chk("b3_valid0", 32'(x_valid), 1);
        chk("b3_x0",     32'(x),       32'hE1);
        chk("b3_busy",   32'(busy),    1);
        tick();
        chk("b3_x1",     32'(x),       32'h70);
        chk("b3_valid1", 32'(x_valid), 1);
`ifdef FIR_SRC_GOLDEN_EN
        chk("b3_y0",     32'(y_g),       28);
        chk("b3_yv0",    32'(y_g_valid), 1);
`endif
        tick();
        chk("b3_x2",     32'(x),       32'h38);
`ifdef FIR_SRC_GOLDEN_EN
        chk("b3_y1",     32'(y_g),     42);
`endif
        tick();
        chk("b3_done",   32'(done),    1);
        chk("b3_dvalid", 32'(x_valid), 0);
        chk("b3_dbusy",  32'(busy),    1);
`ifdef FIR_SRC_GOLDEN_EN
        chk("b3_y2",     32'(y_g),       49);
        chk("b3_yv2",    32'(y_g_valid), 1);
`endif
        tick();
        chk("b3_done_once", 32'(done), 0);
        chk("b3_idle",      32'(busy), 0);

        // burst of 2 with gap 3
        start = 1'b1; burst_len = 16'd2; gap = 4'd3;
        tick(); start = 1'b0;
        chk("g_valid_a", 32'(x_valid), 1);
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("g_gap_valid", 32'(x_valid), 0);
            chk("g_gap_busy",  32'(busy),    1);
        end
        tick();
        chk("g_valid_b", 32'(x_valid), 1);
        tick();
        chk("g_done",    32'(done),    1);
        tick();

        // back-pressure: x holds while x_ready is low
        rst = 1'b1; tick(); rst = 1'b0;
        x_ready = 1'b0; start = 1'b1; burst_len = 16'd2; gap = 4'd0;
        tick(); start = 1'b0;
        for (int i = 0; i < 4; i++) begin
            chk("bp_hold_x",     32'(x),       32'hE1);
            chk("bp_hold_valid", 32'(x_valid), 1);
            if (i < 3) tick();
        end
        x_ready = 1'b1;
        tick();
        chk("bp_next_x", 32'(x), 32'h70);
        tick();
        chk("bp_done",   32'(done), 1);
        tick();

        // zero-length burst; start held through DONE must be ignored
        start = 1'b1; burst_len = 16'd0;
        tick(); burst_len = 16'd3;
        chk("z_done",  32'(done),    1);
        chk("z_valid", 32'(x_valid), 0);
        chk("z_busy",  32'(busy),    1);
        tick();
        chk("z_idle",     32'(busy),    0);
        chk("z_no_valid", 32'(x_valid), 0);
        start = 1'b0;
        tick();
        chk("z_ignored",  32'(busy),    0);

        // reset after the 2nd accept of a 5-sample burst
        rst = 1'b1; tick(); rst = 1'b0;
        start = 1'b1; burst_len = 16'd5; gap = 4'd0;
        tick(); start = 1'b0;
        chk("r_x0", 32'(x), 32'hE1);
        tick();
        chk("r_x1", 32'(x), 32'h70);
        tick();
        rst = 1'b1;
        tick();
        chk("r_busy",  32'(busy),    0);
        chk("r_done",  32'(done),    0);
        chk("r_valid", 32'(x_valid), 0);
        chk("r_x",     32'(x),       32'hE1);
`ifdef FIR_SRC_GOLDEN_EN
        chk("r_y_g",   32'(y_g),       0);
        chk("r_y_vld", 32'(y_g_valid), 0);
`endif
        rst = 1'b0;
        tick();
        chk("r_no_done", 32'(done), 0);
        start = 1'b1; burst_len = 16'd1;
        tick(); start = 1'b0;
        chk("r_next_x",     32'(x),       32'hE1);
        chk("r_next_valid", 32'(x_valid), 1);
        tick();
        chk("r_next_done",  32'(done),    1);
        tick();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
